oam_manager: RTL and testbench
==============================

OAM_MANAGER -- requirements
Module: oam_manager

Interface
REQ-001 The block SHALL have parameter OAM_WIDTH, default 32: entry width in bits.
REQ-002 The block SHALL have parameter OAM_DEPTH, default 8: number of entries (index width 3).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port wr_valid, input, 1 bit: the game logic offers a write.
REQ-006 The block SHALL have port wr_ready, output, 1 bit: the block can accept a write.
REQ-007 The block SHALL have port wr_index, input, 3 bits: target entry.
REQ-008 The block SHALL have port wr_data, input, 32 bits: entry contents. Fields: [30:29] type, [28] enable, [27:18] pos_x, [17:8] pos_y, [7:6] dir, [5:3] sprite row, [2:0] sprite col, [31] reserved.
REQ-009 The block SHALL have port commit_req, input, 1 bit: one-cycle pulse marking the back bank complete for this frame.
REQ-010 The block SHALL have port frame_start, input, 1 bit: one-cycle pulse at the start of vertical blanking.
REQ-011 The block SHALL have port rd_addr, input, 3 bits: the renderer's oam_addr.
REQ-012 The block SHALL have port rd_data, output, 32 bits: the renderer's oam_data, taken from the front bank.
REQ-013 The block SHALL have port swap_pending, output, 1 bit: a commit is waiting for frame_start.

Function
REQ-014 The block SHALL hold two banks of OAM_DEPTH x OAM_WIDTH: front (read by the renderer) and back (written by game logic), selected by a 1-bit bank pointer.
REQ-015 rd_data SHALL be registered: rd_data in cycle n+1 = front[rd_addr sampled in cycle n]; rd_addr wraps 7->0 with no special handling.
REQ-016 The FSM SHALL have three states: ACCEPT, PENDING and COPY.
REQ-017 In ACCEPT: wr_ready=1; a write occurs when wr_valid&wr_ready, storing back[wr_index] <= wr_data.
REQ-018 In ACCEPT, commit_req SHALL move the FSM to PENDING; a write accepted in the same cycle as commit_req is part of the commit.
REQ-019 In PENDING: wr_ready=0 and swap_pending=1; commit_req is ignored.
REQ-020 On frame_start in PENDING, the bank pointer SHALL toggle and the FSM SHALL move to COPY.
REQ-021 If commit_req and frame_start occur together in ACCEPT, the swap SHALL occur in that cycle and the FSM SHALL go directly to COPY.
REQ-022 After a swap, rd_data SHALL come from the new front bank from the next cycle onward.
REQ-023 In COPY: wr_ready=0; a 3-bit counter SHALL perform back[k] <= front[k] for k=0..7, one entry per cycle, taking exactly 8 cycles; the FSM then returns to ACCEPT.
REQ-024 frame_start outside PENDING SHALL have no effect; frame_start during COPY SHALL be ignored.
REQ-025 wr_index SHALL be used modulo OAM_DEPTH; bit [31] SHALL be stored as written.

Reset
REQ-026 On reset, both banks SHALL be cleared to 0 (all entries disabled), the bank pointer SHALL be 0 and the FSM SHALL be in ACCEPT.
REQ-027 While reset is asserted, rd_data=0, wr_ready=0 and swap_pending=0; wr_ready=1 from the first clock edge after release.
REQ-028 Reset during PENDING or COPY SHALL abort the operation immediately; no partial swap or copy SHALL survive.

Configuration
REQ-029 Macro OAM_POS_CLAMP_EN SHALL control position clamping on accepted writes.
REQ-030 With OAM_POS_CLAMP_EN defined, pos_x > 608 SHALL be stored as 608 and pos_y > 448 SHALL be stored as 448, keeping a 32x32 sprite inside 640x480; all other fields are unchanged.
REQ-031 Without OAM_POS_CLAMP_EN, wr_data SHALL be stored unmodified.

Verification
REQ-032 Reset, then rd_addr sweeps 0..7 -> rd_data=0 every cycle; wr_ready=1 after release.
REQ-033 Write idx3=0x1004_0800, commit, frame_start -> rd_addr=3 returns 0x1004_0800 the cycle after the swap; wr_ready=0 for exactly 8 cycles, then back[3] = 0x1004_0800.
REQ-034 Commit with no frame_start for 1000 cycles -> swap_pending=1, wr_ready=0 and rd_data unchanged throughout.
REQ-035 commit_req, frame_start and a write to idx7 in the same cycle -> swap in that cycle, and idx7 is visible on rd_data after the swap.
REQ-036 Reset asserted at COPY cycle 4 -> all entries read 0 and the bank pointer is 0.
REQ-037 With OAM_POS_CLAMP_EN defined, write pos_x=700, pos_y=479 -> stored 608 and 448; without it, stored 700 and 479.

Source files
------------

// File: rtl/oam_manager.sv
// Double-buffered sprite attribute memory: game logic fills the back bank, a commit swaps
// banks at frame_start, then the new front bank is copied into the back. Optional macro OAM_POS_CLAMP_EN.
module oam_manager #(
  parameter int unsigned OAM_WIDTH = 32,
  parameter int unsigned OAM_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [$clog2(OAM_DEPTH)-1:0] wr_index,
  input  logic [OAM_WIDTH-1:0]         wr_data,
  input  logic                         commit_req,
  input  logic                         frame_start,
  input  logic [$clog2(OAM_DEPTH)-1:0] rd_addr,
  output logic [OAM_WIDTH-1:0]         rd_data,
  output logic                         swap_pending
);
  localparam int unsigned IDX_W = $clog2(OAM_DEPTH);

  typedef enum logic [1:0] {ACCEPT, PENDING, COPY} state_t;

  state_t               state, state_next;
  logic [OAM_WIDTH-1:0] mem [2][OAM_DEPTH];
  logic                 bank_ptr;
  logic                 ready_en;
  logic                 do_swap;
  logic                 wr_fire;
  logic                 front_sel;
  logic [IDX_W-1:0]     copy_cnt;
  logic [IDX_W-1:0]     wr_idx;
  logic [IDX_W-1:0]     rd_idx;
  logic [OAM_WIDTH-1:0] wr_store;

  // Keeps a 32x32 sprite inside 640x480 when clamping is compiled in.
  function automatic logic [OAM_WIDTH-1:0] store_value(input logic [OAM_WIDTH-1:0] d);
    logic [OAM_WIDTH-1:0] v;
    v = d;
`ifdef OAM_POS_CLAMP_EN
    if (d[27:18] > 10'd608) v[27:18] = 10'd608;
    if (d[17:8]  > 10'd448) v[17:8]  = 10'd448;
`endif
    return v;
  endfunction

  assign wr_idx    = IDX_W'(32'(wr_index) % OAM_DEPTH);
  assign rd_idx    = IDX_W'(32'(rd_addr) % OAM_DEPTH);
  assign wr_store  = store_value(wr_data);
  assign wr_fire   = wr_valid & wr_ready;
  assign front_sel = do_swap ? ~bank_ptr : bank_ptr;

  always_comb begin
    state_next   = state;
    wr_ready     = 1'b0;
    swap_pending = 1'b0;
    do_swap      = 1'b0;
    case (state)
      ACCEPT: begin
        wr_ready = ready_en;
        if (ready_en && commit_req) begin
          if (frame_start) begin
            do_swap    = 1'b1;
            state_next = COPY;
          end else begin
            state_next = PENDING;
          end
        end
      end
      PENDING: begin
        swap_pending = 1'b1;
        if (frame_start) begin
          do_swap    = 1'b1;
          state_next = COPY;
        end
      end
      COPY: begin
        if (copy_cnt == IDX_W'(OAM_DEPTH - 1)) state_next = ACCEPT;
      end
      default: state_next = ACCEPT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ACCEPT;
      ready_en <= 1'b0;
      bank_ptr <= 1'b0;
      copy_cnt <= '0;
      rd_data  <= '0;
      mem      <= '{default: '0};
    end else begin
      state    <= state_next;
      ready_en <= 1'b1;
      if (do_swap) bank_ptr <= ~bank_ptr;
      copy_cnt <= (state == COPY) ? copy_cnt + 1'b1 : '0;
      if (wr_fire) mem[~bank_ptr][wr_idx] <= wr_store;
      if (state == COPY) mem[~bank_ptr][copy_cnt] <= mem[bank_ptr][copy_cnt];
      // On the swap edge read the incoming front bank, forwarding a same-cycle write into it.
      if (do_swap && wr_fire && (wr_idx == rd_idx)) rd_data <= wr_store;
      else                                          rd_data <= mem[front_sel][rd_idx];
    end
  end
endmodule

// File: tb/tb_oam_manager.sv
// Randomized bench for oam_manager against a bank/flag level reference model,
// with directed scenarios for reset, commit/swap timing, long pending, same-cycle swap, clamping and reset abort.
module tb_oam_manager;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_valid, wr_ready;
  logic [2:0]  wr_index;
  logic [31:0] wr_data;
  logic        commit_req, frame_start;
  logic [2:0]  rd_addr;
  logic [31:0] rd_data;
  logic        swap_pending;

  int n_checks = 0;
  int n_errors = 0;

  oam_manager #(.OAM_WIDTH(32), .OAM_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_index(wr_index), .wr_data(wr_data), .commit_req(commit_req),
    .frame_start(frame_start), .rd_addr(rd_addr), .rd_data(rd_data),
    .swap_pending(swap_pending)
  );

  always #5 clk = ~clk;

  // Reference model: two banks, a front pointer, a "commit waiting" flag and a copy countdown.
  logic [31:0] m_bank [2][8];
  bit          m_ptr;
  bit          m_ready_en;
  bit          m_pending;
  int          m_copy_left;
  logic [31:0] m_rd;

  function automatic logic [31:0] clamp_val(input logic [31:0] d);
    logic [31:0] r;
    r = d;
`ifdef OAM_POS_CLAMP_EN
    begin
      int unsigned x, y;
      x = (d >> 18) & 32'h3FF;
      y = (d >> 8) & 32'h3FF;
      if (x > 608) x = 608;
      if (y > 448) y = 448;
      r = (d & ~32'h0FFF_FF00) | (x << 18) | (y << 8);
    end
`endif
    return r;
  endfunction

  task automatic model_reset();
    foreach (m_bank[b, k]) m_bank[b][k] = '0;
    m_ptr = 1'b0;
    m_ready_en = 1'b0;
    m_pending = 1'b0;
    m_copy_left = 0;
    m_rd = '0;
  endtask

  function automatic bit model_ready();
    return m_ready_en && !m_pending && (m_copy_left == 0);
  endfunction

  task automatic model_edge();
    bit accept, swap;
    logic [2:0] k;
    if (reset) begin
      model_reset();
      return;
    end
    accept = model_ready();
    swap = 1'b0;
    if (m_copy_left > 0) begin
      k = 3'(8 - m_copy_left);
      m_bank[!m_ptr][k] = m_bank[m_ptr][k];
      m_copy_left--;
    end
    if (accept && wr_valid) m_bank[!m_ptr][wr_index] = clamp_val(wr_data);
    if (accept && commit_req) begin
      if (frame_start) swap = 1'b1;
      else m_pending = 1'b1;
    end else if (m_pending && frame_start) begin
      swap = 1'b1;
      m_pending = 1'b0;
    end
    if (swap) begin
      m_ptr = !m_ptr;
      m_copy_left = 8;
    end
    m_rd = m_bank[m_ptr][rd_addr];
    m_ready_en = 1'b1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare outputs mid-cycle, then advance the model on the edge and return just after it.
  task automatic cycle();
    @(negedge clk);
    check("wr_ready", 32'(wr_ready), 32'(model_ready()));
    check("swap_pending", 32'(swap_pending), 32'(m_pending));
    check("rd_data", rd_data, m_rd);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    wr_valid = 0; commit_req = 0; frame_start = 0;
  endtask

  int busy;
  logic [31:0] cdata;
  int unsigned exp_x, exp_y;

  initial begin
    wr_valid = 0; wr_index = 0; wr_data = 0; commit_req = 0; frame_start = 0; rd_addr = 0;
    model_reset();
    #1 reset = 1;
    repeat (3) cycle();
    reset = 0;
    cycle();
    check("ready_after_rst", 32'(wr_ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      cycle();
      check("rst_sweep", rd_data, 32'd0);
    end

    // Write, commit, then frame_start; new data visible right after the swap.
    wr_valid = 1; wr_index = 3; wr_data = 32'h1004_0800;
    cycle();
    idle(); commit_req = 1;
    cycle();
    idle();
    check("pending_set", 32'(swap_pending), 32'd1);
    frame_start = 1; rd_addr = 3;
    cycle();
    idle();
    check("swap_rd3", rd_data, 32'h1004_0800);
    busy = 0;
    for (int i = 0; i < 20 && !wr_ready; i++) begin
      busy++;
      cycle();
    end
    check("copy_len", 32'(busy), 32'd8);
    commit_req = 1; frame_start = 1; rd_addr = 3;
    cycle();
    idle();
    check("back3_copied", rd_data, 32'h1004_0800);
    repeat (8) cycle();

    // Commit held for 1000 cycles with no frame_start.
    wr_valid = 1; wr_index = 5; wr_data = 32'hA5A5_0001; commit_req = 1; rd_addr = 5;
    cycle();
    idle();
    for (int i = 0; i < 1000; i++) begin
      wr_valid = 1'($urandom); wr_index = 3'($urandom); wr_data = $urandom;
      commit_req = 1'($urandom);
      cycle();
    end
    idle();
    check("hold_pending", 32'(swap_pending), 32'd1);
    check("hold_ready", 32'(wr_ready), 32'd0);
    check("hold_rd5", rd_data, 32'd0);
    frame_start = 1;
    cycle();
    idle();
    check("late_swap_rd5", rd_data, 32'hA5A5_0001);
    repeat (8) cycle();

    // commit, frame_start and a write all in one cycle.
    wr_valid = 1; wr_index = 7; wr_data = 32'h7777_1234;
    commit_req = 1; frame_start = 1; rd_addr = 7;
    cycle();
    idle();
    check("same_cycle_rd7", rd_data, 32'h7777_1234);
    check("same_cycle_ready", 32'(wr_ready), 32'd0);
    repeat (8) cycle();

    // Position clamping.
    cdata = (32'd1 << 29) | (32'd1 << 28) | (32'd700 << 18) | (32'd479 << 8) | 32'h2A;
`ifdef OAM_POS_CLAMP_EN
    exp_x = 608; exp_y = 448;
`else
    exp_x = 700; exp_y = 479;
`endif
    wr_valid = 1; wr_index = 2; wr_data = cdata; commit_req = 1; frame_start = 1; rd_addr = 2;
    cycle();
    idle();
    check("clamp_x", (rd_data >> 18) & 32'h3FF, exp_x);
    check("clamp_y", (rd_data >> 8) & 32'h3FF, exp_y);
    check("clamp_other", rd_data & ~32'h0FFF_FF00, cdata & ~32'h0FFF_FF00);
    repeat (8) cycle();

    // Reset during the copy phase.
    wr_valid = 1; wr_index = 1; wr_data = 32'hDEAD_BEEF; commit_req = 1; frame_start = 1; rd_addr = 1;
    cycle();
    idle();
    repeat (4) cycle();
    reset = 1;
    model_reset();
    #1;
    check("abort_rd", rd_data, 32'd0);
    check("abort_ready", 32'(wr_ready), 32'd0);
    cycle();
    reset = 0;
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      cycle();
      check("abort_sweep", rd_data, 32'd0);
    end
    commit_req = 1; frame_start = 1; rd_addr = 1;
    cycle();
    idle();
    check("abort_no_survivor", rd_data, 32'd0);
    repeat (8) cycle();

    // Randomized traffic with occasional asynchronous reset.
    for (int i = 0; i < 4000; i++) begin
      wr_valid = 1'($urandom); wr_index = 3'($urandom); wr_data = $urandom;
      commit_req = ($urandom_range(0, 19) == 0);
      frame_start = ($urandom_range(0, 11) == 0);
      rd_addr = 3'($urandom);
      if ($urandom_range(0, 799) == 0) begin
        reset = 1;
        model_reset();
      end else begin
        reset = 0;
      end
      cycle();
    end
    reset = 0;
    idle();
    repeat (2) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
